// File: rtl/load_store_unit_if.sv
// Bundle between execute, the load/store unit and the data memory.
//   req_*  : request from execute (valid/ready handshake)
//   mem_*  : word-indexed data memory port (combinational read, level write)
//   resp_* : registered one-cycle write-back response, plus exception
// master = environment side (execute + memory), slave = load_store_unit.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [3:0]            req_rd;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic [3:0]            resp_rd;
  logic                  resp_load;
  logic                  exception;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd, mem_rdata,
    input  req_ready, mem_addr, mem_wdata, mem_write,
    input  resp_valid, resp_data, resp_rd, resp_load, exception
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd, mem_rdata,
    output req_ready, mem_addr, mem_wdata, mem_write,
    output resp_valid, resp_data, resp_rd, resp_load, exception
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one lw/sw/lb/sb request at a time, drives the
// data memory (read-modify-write for sb) and returns a one-cycle response.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset
//   bus  : load_store_unit_if.slave (request, memory port, response)
// Out-of-range word indices (>= MEM_SIZE) skip memory access and respond
// with exception=1.
module load_store_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_SIZE   = 3
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  typedef enum logic [1:0] {OP_LW = 2'b00, OP_SW = 2'b01, OP_LB = 2'b10, OP_SB = 2'b11} op_t;

  state_t                state;
  op_t                   op_q;
  logic                  bsel_q;
  logic [7:0]            wbyte_q;
  logic                  write_q;

  logic [ADDR_WIDTH-1:0] req_widx;
  logic                  req_fault;
  logic [7:0]            rbyte;
  logic [DATA_WIDTH-1:0] rbyte_ext;
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    // Byte ops (op[1]=1) address bytes; the word index drops the byte select.
    req_widx  = bus.req_op[1] ? (bus.req_addr >> 1) : bus.req_addr;
    req_fault = req_widx >= ADDR_WIDTH'(MEM_SIZE);
    rbyte     = bus.mem_rdata[{bsel_q, 3'b000} +: 8];
    rbyte_ext = {{(DATA_WIDTH-8){rbyte[7]}}, rbyte};
    merged    = bus.mem_rdata;
    merged[{bsel_q, 3'b000} +: 8] = wbyte_q;
  end

  // The strobe is registered, but gated with rst so an in-flight write is
  // suppressed during the very cycle reset is asserted.
  assign bus.mem_write = write_q & rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      op_q           <= OP_LW;
      bsel_q         <= 1'b0;
      wbyte_q        <= '0;
      write_q        <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_rd    <= '0;
      bus.resp_load  <= 1'b0;
      bus.exception  <= 1'b0;
    end else begin
      write_q        <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_load  <= 1'b0;
      bus.exception  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            op_q          <= op_t'(bus.req_op);
            bsel_q        <= bus.req_addr[0];
            wbyte_q       <= bus.req_wdata[7:0];
            bus.resp_rd   <= bus.req_rd;
            bus.resp_data <= '0;
            bus.req_ready <= 1'b0;
            if (req_fault) begin
              bus.mem_addr   <= '0;
              bus.resp_valid <= 1'b1;
              bus.exception  <= 1'b1;
              state          <= RESP;
            end else begin
              bus.mem_addr <= req_widx;
              if (op_t'(bus.req_op) == OP_SW) begin
                bus.mem_wdata <= bus.req_wdata;
                write_q       <= 1'b1;
                state         <= WRITE;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          // mem_rdata is captured at the end of READ: either as the merged
          // store word for sb or as the load result.
          if (op_q == OP_SB) begin
            bus.mem_wdata <= merged;
            write_q       <= 1'b1;
            state         <= WRITE;
          end else begin
            bus.resp_data  <= (op_q == OP_LB) ? rbyte_ext : bus.mem_rdata;
            bus.resp_load  <= 1'b1;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end
        end
        WRITE: begin
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  load_store_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_SIZE(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data memory environment: combinational read, write on clock edge,
  // reinitialised by reset.
  logic [15:0] dmem [3];
  int wr_total    = 0;
  int rst_wr_seen = 0;
  logic [15:0] wr_addr = '0;
  logic [15:0] wr_data = '0;

  always @(posedge clk) begin
    if (!rst) begin
      dmem[0] <= 16'h2BCD;
      dmem[1] <= 16'h0000;
      dmem[2] <= 16'h0000;
    end else if (bus.mem_write && bus.mem_addr < 16'd3) begin
      dmem[bus.mem_addr[1:0]] <= bus.mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (bus.mem_write) begin
      wr_total <= wr_total + 1;
      wr_addr  <= bus.mem_addr;
      wr_data  <= bus.mem_wdata;
      if (!rst) rst_wr_seen <= rst_wr_seen + 1;
    end
  end

  assign bus.mem_rdata = (bus.mem_addr < 16'd3) ? dmem[bus.mem_addr[1:0]] : 16'hDEAD;

  // Reference model state
  logic [15:0] ref_mem [3];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    ref_mem[0] = 16'h2BCD;
    ref_mem[1] = 16'h0000;
    ref_mem[2] = 16'h0000;
  endtask

  // Expected outcome of one request, straight from the instruction semantics.
  task automatic model(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                       output logic [15:0] e_data, output logic e_load, output logic e_exc,
                       output int e_lat, output int e_nwr,
                       output logic [15:0] e_waddr, output logic [15:0] e_wdata);
    int unsigned widx;
    int unsigned sh;
    logic [15:0] w;
    logic [15:0] mask;
    logic [7:0]  b;
    widx = op[1] ? 32'(addr) / 2 : 32'(addr);
    sh   = (32'(addr) % 2) * 8;
    e_data = '0; e_load = 0; e_exc = 0; e_nwr = 0; e_waddr = '0; e_wdata = '0; e_lat = 1;
    if (widx >= 3) begin
      e_exc = 1;
      return;
    end
    w = ref_mem[widx];
    case (op)
      2'b00: begin e_data = w; e_load = 1; e_lat = 2; end
      2'b01: begin
        ref_mem[widx] = wdata;
        e_nwr = 1; e_waddr = 16'(widx); e_wdata = wdata; e_lat = 2;
      end
      2'b10: begin
        b = 8'((w >> sh) & 16'h00FF);
        e_data = (b >= 8'd128) ? (16'(b) + 16'hFF00) : 16'(b);
        e_load = 1; e_lat = 2;
      end
      default: begin
        mask = 16'h00FF << sh;
        w = (w & ~mask) | (16'(wdata[7:0]) << sh);
        ref_mem[widx] = w;
        e_nwr = 1; e_waddr = 16'(widx); e_wdata = w; e_lat = 3;
      end
    endcase
  endtask

  // Starts and ends at a negedge; the request stays asserted while the unit
  // is busy so that premature re-acceptance would be visible.
  task automatic do_req(input string tag, input logic [1:0] op, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [3:0] rd);
    logic [15:0] ed, ewa, ewd;
    logic el, ee;
    int elat, enw, w0, lat;
    bit busy_ok;
    model(op, addr, wdata, ed, el, ee, elat, enw, ewa, ewd);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_rd    = rd;
    chk($sformatf("%s.ready", tag), 32'(bus.req_ready), 1);
    w0 = wr_total;
    @(posedge clk);
    lat = 0;
    busy_ok = 1;
    do begin
      @(negedge clk);
      lat++;
      if (bus.req_ready !== 1'b0) busy_ok = 0;
    end while (bus.resp_valid !== 1'b1 && lat < 8);
    bus.req_valid = 1'b0;
    chk($sformatf("%s.latency", tag), 32'(lat), 32'(elat));
    chk($sformatf("%s.data", tag), 32'(bus.resp_data), 32'(ed));
    chk($sformatf("%s.load", tag), 32'(bus.resp_load), 32'(el));
    chk($sformatf("%s.exc", tag), 32'(bus.exception), 32'(ee));
    chk($sformatf("%s.rd", tag), 32'(bus.resp_rd), 32'(rd));
    chk($sformatf("%s.busy", tag), 32'(busy_ok), 1);
    chk($sformatf("%s.nwr", tag), 32'(wr_total - w0), 32'(enw));
    if (enw == 1) begin
      chk($sformatf("%s.waddr", tag), 32'(wr_addr), 32'(ewa));
      chk($sformatf("%s.wdata", tag), 32'(wr_data), 32'(ewd));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ref_reset();
    @(negedge clk);
  endtask

  initial begin
    logic [1:0]  op;
    logic [15:0] addr;
    bit quiet;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_rd    = '0;
    ref_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", 32'(bus.req_ready), 1);
    chk("rst.mem_write", 32'(bus.mem_write), 0);
    chk("rst.resp_valid", 32'(bus.resp_valid), 0);
    chk("rst.resp_load", 32'(bus.resp_load), 0);
    chk("rst.exception", 32'(bus.exception), 0);
    chk("rst.resp_data", 32'(bus.resp_data), 0);
    chk("rst.resp_rd", 32'(bus.resp_rd), 0);
    chk("rst.mem_addr", 32'(bus.mem_addr), 0);
    chk("rst.mem_wdata", 32'(bus.mem_wdata), 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed sequence
    do_req("lw0", 2'b00, 16'd0, 16'h0000, 4'd1);
    do_req("sw2", 2'b01, 16'd2, 16'h1234, 4'd2);
    do_req("lw2", 2'b00, 16'd2, 16'h0000, 4'd3);
    do_req("sb1", 2'b11, 16'd1, 16'h00EF, 4'd4);
    do_req("lb1", 2'b10, 16'd1, 16'h0000, 4'd5);
    do_reset();
    do_req("lb0", 2'b10, 16'd0, 16'h0000, 4'd6);
    do_req("sb0", 2'b11, 16'd0, 16'h0041, 4'd7);
    do_req("lw0b", 2'b00, 16'd0, 16'h0000, 4'd8);
    do_req("sw3", 2'b01, 16'd3, 16'h5555, 4'd9);
    do_req("lb6", 2'b10, 16'd6, 16'h0000, 4'd10);
    do_req("lw2b", 2'b00, 16'd2, 16'h0000, 4'd11);

    // Reset while the sw is in WRITE
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_addr  = 16'd1;
    bus.req_wdata = 16'hAAAA;
    bus.req_rd    = 4'd12;
    @(posedge clk);
    @(negedge clk);
    chk("midrst.write_pre", 32'(bus.mem_write), 1);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst.write_in_rst", 32'(bus.mem_write), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ref_reset();
    quiet = 1;
    repeat (3) begin
      if (bus.resp_valid !== 1'b0) quiet = 0;
      @(negedge clk);
    end
    chk("midrst.no_resp", 32'(quiet), 1);
    do_req("midrst.lw1", 2'b00, 16'd1, 16'h0000, 4'd13);

    // Randomised requests against the reference model
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      addr = op[1] ? 16'($urandom_range(0, 7)) : 16'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) addr = 16'hFFFE;
      do_req($sformatf("rnd%0d", i), op, addr, 16'($urandom), 4'($urandom));
    end

    for (int k = 0; k < 3; k++)
      chk($sformatf("final.mem%0d", k), 32'(dmem[k]), 32'(ref_mem[k]));
    chk("rst.no_write", 32'(rst_wr_seen), 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
